// File: rtl/imm_extend_pipe_pkg.sv
// Shared definitions for the immediate extender: mode encodings driven by the control unit.
package imm_extend_pipe_pkg;

    localparam logic [1:0] EXT_ZERO  = 2'd0;
    localparam logic [1:0] EXT_SIGN  = 2'd1;
    localparam logic [1:0] EXT_SHIFT = 2'd2;
    localparam logic [1:0] EXT_UPPER = 2'd3;

endpackage

// File: rtl/imm_extend_pipe_skid_buffer.sv
// Two-entry valid/ready register slice: main output register plus one skid entry.
module skid_buffer #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             skid_full;
    logic [WIDTH-1:0] skid_data;
    logic             in_fire_c;

    assign in_fire_c = in_valid & in_ready;
    // skid_full is a flop, so in_ready stays a registered output
    assign in_ready  = ~skid_full;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_full <= 1'b0;
            skid_data <= '0;
        end else if (skid_full) begin
            // input is blocked; the skid entry moves up when main drains
            if (out_ready) begin
                out_data  <= skid_data;
                skid_full <= 1'b0;
            end
        end else if (in_fire_c) begin
            if (!out_valid || out_ready) begin
                out_valid <= 1'b1;
                out_data  <= in_data;
            end else begin
                skid_data <= in_data;
                skid_full <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: zero/sign/sign-shift/upper modes with offset overflow flag.
module imm_extend_pipe
    import imm_extend_pipe_pkg::*;
#(
    parameter int unsigned IN_W  = 5,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned SHIFT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf
);

    localparam int unsigned PW = OUT_W + SHIFT;
    localparam int unsigned UP = OUT_W - IN_W;

    logic [PW-1:0]    shifted_c;
    logic [SHIFT:0]   hi_c;
    logic [OUT_W-1:0] ext_c;
    logic             ovf_c;
    logic [OUT_W:0]   out_word;

    // exact signed product fits in PW bits; overflow when the bits above OUT_W-1 disagree
    always_comb begin
        shifted_c = PW'($signed(in_data)) << SHIFT;
        hi_c      = shifted_c[PW-1:OUT_W-1];
        ext_c     = '0;
        ovf_c     = 1'b0;
        case (in_mode)
            EXT_ZERO:  ext_c = OUT_W'(in_data);
            EXT_SIGN:  ext_c = OUT_W'($signed(in_data));
            EXT_SHIFT: begin
                ext_c = shifted_c[OUT_W-1:0];
                ovf_c = ~((&hi_c) | ~(|hi_c));
            end
            default:   ext_c = OUT_W'(in_data) << UP;
        endcase
    end

    skid_buffer #(
        .WIDTH(OUT_W + 1)
    ) u_skid (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({ovf_c, ext_c}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_word)
    );

    assign {out_ovf, out_data} = out_word;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench: default build (a) and SHIFT=4 build (b), directed vectors plus scoreboard.
module tb_imm_extend_pipe;

    logic       clock;
    logic       reset;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
    logic [4:0] a_in_data;
    logic [1:0] a_in_mode;
    logic [7:0] a_out_data;

    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
    logic [4:0] b_in_data;
    logic [1:0] b_in_mode;
    logic [7:0] b_out_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] qa[$];
    logic [8:0] qb[$];
    int         pushed_a, pushed_b, pops_a, pops_b;
    int         first_pop_a, last_pop_a;
    logic       stall_a = 1'b0, stall_b = 1'b0;
    logic [8:0] prev_a, prev_b;

    imm_extend_pipe #(.IN_W(5), .OUT_W(8), .SHIFT(1)) dut_a (
        .clock(clock), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ovf(a_out_ovf)
    );

    imm_extend_pipe #(.IN_W(5), .OUT_W(8), .SHIFT(4)) dut_b (
        .clock(clock), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ovf(b_out_ovf)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference: arithmetic on the signed integer value, not on bit slices
    function automatic logic [8:0] model(input logic [4:0] d, input logic [1:0] m, input int sh);
        int sv, p;
        logic [7:0] r;
        logic o;
        sv = d[4] ? int'(d) - 32 : int'(d);
        o  = 1'b0;
        case (m)
            2'd0: r = 8'(d);
            2'd1: r = 8'(sv);
            2'd2: begin
                p = sv * (1 << sh);
                r = 8'(p);
                o = (p > 127) || (p < -128);
            end
            default: r = 8'({d, 3'b000});
        endcase
        return {o, r};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_random(input int cycles, input int pv, input int pr, input int max_items);
        logic [8:0] e;
        for (int c = 0; c < cycles; c++) begin
            a_in_valid  = (pushed_a < max_items) && ($urandom_range(99) < pv);
            a_in_data   = 5'($urandom);
            a_in_mode   = 2'($urandom);
            a_out_ready = $urandom_range(99) < pr;
            b_in_valid  = (pushed_b < max_items) && ($urandom_range(99) < pv);
            b_in_data   = 5'($urandom);
            b_in_mode   = 2'($urandom);
            b_out_ready = $urandom_range(99) < pr;
            if (stall_a) check("a_stable", 32'({a_out_valid, a_out_ovf, a_out_data}), 32'({1'b1, prev_a}));
            if (stall_b) check("b_stable", 32'({b_out_valid, b_out_ovf, b_out_data}), 32'({1'b1, prev_b}));
            if (a_out_valid && a_out_ready) begin
                check("a_nonempty", 32'(qa.size() != 0), 32'd1);
                if (qa.size() != 0) begin
                    e = qa.pop_front();
                    check("a_item", 32'({a_out_ovf, a_out_data}), 32'(e));
                    if (pops_a == 0) first_pop_a = c;
                    last_pop_a = c;
                    pops_a++;
                end
            end
            if (b_out_valid && b_out_ready) begin
                check("b_nonempty", 32'(qb.size() != 0), 32'd1);
                if (qb.size() != 0) begin
                    e = qb.pop_front();
                    check("b_item", 32'({b_out_ovf, b_out_data}), 32'(e));
                    pops_b++;
                end
            end
            stall_a = a_out_valid && !a_out_ready;
            prev_a  = {a_out_ovf, a_out_data};
            stall_b = b_out_valid && !b_out_ready;
            prev_b  = {b_out_ovf, b_out_data};
            if (a_in_valid && a_in_ready) begin
                qa.push_back(model(a_in_data, a_in_mode, 1));
                pushed_a++;
            end
            if (b_in_valid && b_in_ready) begin
                qb.push_back(model(b_in_data, b_in_mode, 4));
                pushed_b++;
            end
            step();
        end
    endtask

    logic [4:0] da[5] = '{5'b10110, 5'b10110, 5'b10110, 5'b10110, 5'b01010};
    logic [1:0] ma[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
    logic [7:0] ea[5] = '{8'h16, 8'hF6, 8'hEC, 8'hB0, 8'h0A};
    logic [4:0] db[4] = '{5'b10110, 5'b11110, 5'b00111, 5'b01000};
    logic [8:0] eb[4] = '{9'h160, 9'h0E0, 9'h070, 9'h180};

    initial begin
        clock = 1'b0;
        reset = 1'b1;
        {a_in_valid, a_in_data, a_in_mode} = '0;
        {b_in_valid, b_in_data, b_in_mode} = '0;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        #12;
        check("rst_a_valid", 32'(a_out_valid), 32'd0);
        check("rst_a_ready", 32'(a_in_ready), 32'd1);
        check("rst_a_data", 32'({a_out_ovf, a_out_data}), 32'd0);
        check("rst_b_valid", 32'(b_out_valid), 32'd0);
        step();
        reset = 1'b0;
        step();

        // all four modes on the default build, one result per accept
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = da[i];
            a_in_mode  = ma[i];
            step();
            check("dir_a_valid", 32'(a_out_valid), 32'd1);
            check("dir_a_data", 32'(a_out_data), 32'(ea[i]));
            check("dir_a_ovf", 32'(a_out_ovf), 32'd0);
            check("dir_a_ready", 32'(a_in_ready), 32'd1);
        end
        a_in_valid = 1'b0;
        step();
        check("dir_a_idle", 32'(a_out_valid), 32'd0);

        // SHIFT=4 offsets with and without overflow
        for (int i = 0; i < 4; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = db[i];
            b_in_mode  = 2'd2;
            step();
            check("dir_b_valid", 32'(b_out_valid), 32'd1);
            check("dir_b_word", 32'({b_out_ovf, b_out_data}), 32'(eb[i]));
        end
        b_in_valid = 1'b0;
        step();

        // backpressure: two accepted, third waits for the first drain
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_mode   = 2'd0;
        a_in_data   = 5'd1;
        step();
        check("bp_ready1", 32'(a_in_ready), 32'd1);
        check("bp_data1", 32'(a_out_data), 32'h01);
        a_in_data = 5'd2;
        step();
        check("bp_ready2", 32'(a_in_ready), 32'd0);
        a_in_data = 5'd3;
        step();
        check("bp_hold_ready", 32'(a_in_ready), 32'd0);
        check("bp_hold_data", 32'({a_out_valid, a_out_data}), 32'h101);
        a_out_ready = 1'b1;
        step();
        check("bp_drain1", 32'({a_out_valid, a_out_data}), 32'h102);
        check("bp_ready_back", 32'(a_in_ready), 32'd1);
        step();
        a_in_valid = 1'b0;
        check("bp_third", 32'({a_out_valid, a_out_data}), 32'h103);
        step();
        check("bp_empty", 32'(a_out_valid), 32'd0);

        // streaming: 32 items back to back
        pushed_a = 0; pushed_b = 0; pops_a = 0; pops_b = 0;
        first_pop_a = -1; last_pop_a = -1;
        run_random(40, 100, 100, 32);
        check("stream_count", 32'(pops_a), 32'd32);
        check("stream_span", 32'(last_pop_a - first_pop_a), 32'd31);
        check("stream_b_count", 32'(pops_b), 32'd32);

        // random valid/ready toggling, then drain
        pushed_a = 0; pushed_b = 0;
        run_random(1000, 60, 60, 100000);
        run_random(20, 0, 100, 0);
        check("rand_a_drained", 32'(qa.size()), 32'd0);
        check("rand_b_drained", 32'(qb.size()), 32'd0);

        // asynchronous reset mid-cycle with two items held
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_mode   = 2'd0;
        a_in_data   = 5'd1;
        step();
        a_in_data = 5'd2;
        step();
        a_in_valid = 1'b0;
        check("ar_full", 32'(a_in_ready), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", 32'(a_out_valid), 32'd0);
        check("ar_data", 32'({a_out_ovf, a_out_data}), 32'd0);
        check("ar_ready", 32'(a_in_ready), 32'd1);
        step();
        reset = 1'b0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ar_no_replay", 32'(a_out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
